// File: rtl/mat_pkg.sv
// Shared types, defaults and neighbour geometry for the feature-match engine.
package mat_pkg;

    localparam int IMG_W_DEF    = 160;
    localparam int IMG_H_DEF    = 120;
    localparam int ADDR_W_DEF   = 15;
    localparam int PIX_W_DEF    = 8;
    localparam int DB_DEPTH_DEF = 36;
    localparam int MAX_POS_DEF  = 16;
    localparam int TOL_DEF      = 4;
    localparam int MIN_HIT_DEF  = 6;

    localparam int NBR_COUNT    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        COMPARE,
        RECORD,
        DONE
    } matState_t;

    // Neighbour k as a linear frame-buffer offset: NW, N, NE, W, E, SW, S, SE.
    function automatic int nbrOffset(input int k, input int imgW);
        case (k)
            0:       return -imgW - 1;
            1:       return -imgW;
            2:       return -imgW + 1;
            3:       return -1;
            4:       return 1;
            5:       return imgW - 1;
            6:       return imgW;
            default: return imgW + 1;
        endcase
    endfunction

endpackage

// File: rtl/mat_if.sv
// Job control, frame-buffer / DB read ports and position-store outputs of the engine.
interface mat_if
    import mat_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PIX_W    = PIX_W_DEF,
    parameter int DB_DEPTH = DB_DEPTH_DEF,
    parameter int MAX_POS  = MAX_POS_DEF
) ();
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int DBW = $clog2(DB_DEPTH);
    localparam int PCW = $clog2(MAX_POS + 1);

    logic                      start;
    logic [XW-1:0]             refX;
    logic [YW-1:0]             refY;
    logic                      isFeature;
    logic                      clear;
    logic [ADDR_W-1:0]         fbAddr;
    logic                      fbRdEn;
    logic [PIX_W-1:0]          fbData;
    logic [DBW-1:0]            dbAddr;
    logic [8*PIX_W-1:0]        dbData;
    logic                      busy;
    logic                      done;
    logic                      matPoint;
    logic                      borderReject;
    logic [MAX_POS*ADDR_W-1:0] position;
    logic [PCW-1:0]            posCount;
    logic                      isMatching;
    logic                      overflow;

    modport master (
        output start, refX, refY, isFeature, clear, fbData, dbData,
        input  fbAddr, fbRdEn, dbAddr, busy, done, matPoint, borderReject,
               position, posCount, isMatching, overflow
    );

    modport slave (
        input  start, refX, refY, isFeature, clear, fbData, dbData,
        output fbAddr, fbRdEn, dbAddr, busy, done, matPoint, borderReject,
               position, posCount, isMatching, overflow
    );

endinterface

// File: rtl/mat_cmp.sv
// Combinational 8-pixel tolerance comparator: counts neighbours within TOL of a DB entry.
module mat_cmp
    import mat_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int TOL     = TOL_DEF,
    parameter int MIN_HIT = MIN_HIT_DEF
) (
    input  logic [8*PIX_W-1:0] adjPix,
    input  logic [8*PIX_W-1:0] dbPix,
    output logic [3:0]         hitCount,
    output logic               match
);
    localparam logic [PIX_W:0] TOL_V = (PIX_W+1)'(TOL);
    localparam logic [3:0]     MIN_V = 4'(MIN_HIT);

    logic [PIX_W:0] a, b, diff;

    // Absolute difference per neighbour, one extra bit so the subtraction never wraps.
    always_comb begin
        hitCount = '0;
        a        = '0;
        b        = '0;
        diff     = '0;
        for (int unsigned k = 0; k < NBR_COUNT; k++) begin
            a    = {1'b0, adjPix[k*PIX_W +: PIX_W]};
            b    = {1'b0, dbPix[k*PIX_W +: PIX_W]};
            diff = (a >= b) ? (a - b) : (b - a);
            if (diff <= TOL_V) begin
                hitCount = hitCount + 4'd1;
            end
        end
        match = (hitCount >= MIN_V);
    end

endmodule

// File: rtl/mat_engine.sv
// Feature-match engine: fetches the 3x3 ring around a reference pixel, scans the
// DB for a tolerant match and records matching feature addresses.
module mat_engine
    import mat_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PIX_W    = PIX_W_DEF,
    parameter int DB_DEPTH = DB_DEPTH_DEF,
    parameter int MAX_POS  = MAX_POS_DEF,
    parameter int TOL      = TOL_DEF,
    parameter int MIN_HIT  = MIN_HIT_DEF
) (
    input logic  clock,
    input logic  reset,
    mat_if.slave bus
);
    localparam int DBW = $clog2(DB_DEPTH);
    localparam int PCW = $clog2(MAX_POS + 1);
    localparam logic [DBW-1:0] LAST_ENTRY = DBW'(DB_DEPTH - 1);
    localparam logic [DBW-1:0] FIRST_NEXT = (DB_DEPTH > 1) ? DBW'(1) : '0;
    localparam logic [PCW-1:0] FULL_CNT   = PCW'(MAX_POS);

    matState_t          state;
    logic [ADDR_W-1:0]  refAddr, newRefAddr, fbAddrQ;
    logic               isFeatLat, matched, cmpMatch, refOnBorder;
    logic [3:0]         fetchCnt, hitCount;
    logic [8*PIX_W-1:0] adj;
    logic [DBW-1:0]     evalIdx, dbAddrQ;
    logic [ADDR_W-1:0]  slots [MAX_POS];
    logic [PCW-1:0]     posCnt;
    logic               fbRdEnQ, busyQ, doneQ, matPointQ, borderQ, overflowQ;
    logic               unusedHits;

    function automatic logic [ADDR_W-1:0] nbrAddr(input logic [ADDR_W-1:0] base, input int k);
        return ADDR_W'(int'(base) + nbrOffset(k, IMG_W));
    endfunction

    assign newRefAddr  = ADDR_W'(int'(bus.refY) * IMG_W + int'(bus.refX));
    assign refOnBorder = (bus.refX == '0) || (int'(bus.refX) == IMG_W - 1) ||
                         (bus.refY == '0) || (int'(bus.refY) == IMG_H - 1);

    mat_cmp #(.PIX_W(PIX_W), .TOL(TOL), .MIN_HIT(MIN_HIT)) cmp (
        .adjPix   (adj),
        .dbPix    (bus.dbData),
        .hitCount (hitCount),
        .match    (cmpMatch)
    );

    // Hit count is kept on the comparator for debug visibility only.
    assign unusedHits = ^hitCount;

    // Job sequencer: fetch ring, scan DB, record result, pulse done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            refAddr   <= '0;
            isFeatLat <= 1'b0;
            matched   <= 1'b0;
            fetchCnt  <= '0;
            adj       <= '0;
            evalIdx   <= '0;
            dbAddrQ   <= '0;
            fbAddrQ   <= '0;
            fbRdEnQ   <= 1'b0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
            matPointQ <= 1'b0;
            borderQ   <= 1'b0;
            overflowQ <= 1'b0;
            posCnt    <= '0;
            for (int unsigned i = 0; i < MAX_POS; i++) slots[i] <= '0;
        end else begin
            doneQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        refAddr   <= newRefAddr;
                        isFeatLat <= bus.isFeature;
                        busyQ     <= 1'b1;
                        matPointQ <= 1'b0;
                        borderQ   <= 1'b0;
                        if (refOnBorder) begin
                            borderQ <= 1'b1;
                            doneQ   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            fbAddrQ  <= nbrAddr(newRefAddr, 0);
                            fbRdEnQ  <= 1'b1;
                            fetchCnt <= '0;
                            dbAddrQ  <= '0;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (fetchCnt != '0) begin
                        adj[(int'(fetchCnt) - 1) * PIX_W +: PIX_W] <= bus.fbData;
                    end
                    if (fetchCnt < 4'd7) begin
                        fbAddrQ <= nbrAddr(refAddr, int'(fetchCnt) + 1);
                    end else begin
                        fbRdEnQ <= 1'b0;
                    end
                    fetchCnt <= fetchCnt + 4'd1;
                    if (fetchCnt == 4'd8) begin
                        evalIdx <= '0;
                        dbAddrQ <= FIRST_NEXT;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (cmpMatch || (evalIdx == LAST_ENTRY)) begin
                        matched <= cmpMatch;
                        state   <= RECORD;
                    end else begin
                        evalIdx <= evalIdx + 1'b1;
                        if (dbAddrQ != LAST_ENTRY) dbAddrQ <= dbAddrQ + 1'b1;
                    end
                end
                RECORD: begin
                    if (matched && isFeatLat) begin
                        if (posCnt < FULL_CNT) begin
                            for (int unsigned i = 0; i < MAX_POS; i++) begin
                                if (PCW'(i) == posCnt) slots[i] <= refAddr;
                            end
                            posCnt <= posCnt + 1'b1;
                        end else begin
                            overflowQ <= 1'b1;
                        end
                    end
                    matPointQ <= matched;
                    doneQ     <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busyQ <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Placed after the case so a clear overrides any RECORD write in the same cycle.
            if (bus.clear) begin
                posCnt    <= '0;
                overflowQ <= 1'b0;
                for (int unsigned i = 0; i < MAX_POS; i++) slots[i] <= '0;
            end
        end
    end

    // Flatten the position store onto the output bus.
    always_comb begin
        bus.position = '0;
        for (int unsigned i = 0; i < MAX_POS; i++) begin
            bus.position[i*ADDR_W +: ADDR_W] = slots[i];
        end
    end

    assign bus.fbAddr       = fbAddrQ;
    assign bus.fbRdEn       = fbRdEnQ;
    assign bus.dbAddr       = dbAddrQ;
    assign bus.busy         = busyQ;
    assign bus.done         = doneQ;
    assign bus.matPoint     = matPointQ;
    assign bus.borderReject = borderQ;
    assign bus.posCount     = posCnt;
    assign bus.isMatching   = (posCnt != '0);
    assign bus.overflow     = overflowQ;

endmodule

// File: tb/tb_mat_engine.sv
// Scoreboard bench for mat_engine: directed jobs push expectations, a monitor checks on done.
module tb_mat_engine;
    import mat_pkg::*;

    localparam int W   = 160;
    localparam int H   = 120;
    localparam int AW  = 15;
    localparam int PW  = 8;
    localparam int DBD = 36;
    localparam int MP  = 16;

    typedef struct {
        int lat;
        bit mp;
        bit br;
        int pc;
        bit ov;
        int slotIdx;
        int slotVal;
        int reads;
        int sCyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;

    int nCompared = 0;
    int nMismatch = 0;

    exp_t sbQ[$];
    int   readQ[$];
    int   readCnt;
    int   doneCount;
    int   mPc;
    bit   mOv;

    logic [7:0]  fbMem [0:W*H-1];
    logic [63:0] dbMem [0:DBD-1];

    mat_if #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW), .DB_DEPTH(DBD), .MAX_POS(MP)) dutIf ();

    mat_engine #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW), .DB_DEPTH(DBD),
        .MAX_POS(MP), .TOL(4), .MIN_HIT(6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dutIf)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous frame-buffer and DB memories, one-cycle read latency.
    always @(posedge clock) if (dutIf.fbRdEn) dutIf.fbData <= fbMem[dutIf.fbAddr];
    always @(posedge clock) dutIf.dbData <= dbMem[dutIf.dbAddr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fillFb(input int val);
        for (int i = 0; i < W*H; i++) fbMem[i] = 8'(val);
    endtask

    task automatic setup028();
        fillFb(100);
        for (int i = 0; i < DBD; i++) dbMem[i] = '0;
        dbMem[3] = {8{8'd102}};
    endtask

    // Monitor: checks read addresses as they issue and the full result on done.
    initial begin
        exp_t e;
        int   ea;
        readCnt   = 0;
        doneCount = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (dutIf.fbRdEn) begin
                    readCnt++;
                    if (readQ.size() > 0) begin
                        ea = readQ.pop_front();
                        chk("fb_addr", dutIf.fbAddr, ea);
                    end
                end
                if (dutIf.done) begin
                    if (sbQ.size() == 0) begin
                        chk("sb_pending", sbQ.size(), 1);
                    end else begin
                        e = sbQ.pop_front();
                        chk("latency", cyc - e.sCyc + 1, e.lat);
                        chk("matPoint", dutIf.matPoint, e.mp);
                        chk("borderReject", dutIf.borderReject, e.br);
                        chk("posCount", dutIf.posCount, e.pc);
                        chk("overflow", dutIf.overflow, e.ov);
                        chk("isMatching", dutIf.isMatching, e.pc != 0);
                        chk("read_count", readCnt, e.reads);
                        if (e.slotIdx >= 0)
                            chk("slot", dutIf.position[e.slotIdx*AW +: AW], e.slotVal);
                    end
                    readCnt = 0;
                    doneCount++;
                end
            end
        end
    end

    task automatic runJob(input int x, input int y, input bit feat, input bit expMatch,
                          input int expLat, input int clearAt, input int dupAt);
        exp_t e;
        int   addr;
        bit   border;
        int   rel;
        int   startDone;
        addr      = y*W + x;
        border    = (x == 0) || (x == W-1) || (y == 0) || (y == H-1);
        e.lat     = expLat;
        e.mp      = expMatch && !border;
        e.br      = border;
        e.reads   = border ? 0 : 8;
        e.slotIdx = -1;
        e.slotVal = 0;
        if (!border) for (int k = 0; k < 8; k++) readQ.push_back(addr + nbrOffset(k, W));
        if (clearAt > 0) begin
            mPc = 0;
            mOv = 1'b0;
        end else if (expMatch && feat && !border) begin
            if (mPc < MP) begin
                e.slotIdx = mPc;
                e.slotVal = addr;
                mPc++;
            end else begin
                mOv = 1'b1;
            end
        end
        e.pc = mPc;
        e.ov = mOv;
        @(negedge clock); #1;
        e.sCyc = cyc;
        sbQ.push_back(e);
        dutIf.refX      = x[7:0];
        dutIf.refY      = y[6:0];
        dutIf.isFeature = feat;
        dutIf.start     = 1'b1;
        startDone = doneCount;
        rel = 1;
        while (doneCount == startDone && rel < 200) begin
            @(negedge clock); #1;
            rel++;
            dutIf.start = (rel == dupAt);
            if (rel == dupAt) begin
                dutIf.refX = '0;
                dutIf.refY = '0;
            end
            dutIf.clear = (rel == clearAt);
        end
        dutIf.start = 1'b0;
        dutIf.clear = 1'b0;
        if (doneCount == startDone) chk("job_timeout", doneCount, startDone + 1);
        @(negedge clock); #1;
        chk("busy_after_done", dutIf.busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        reset           = 1'b1;
        dutIf.start     = 1'b0;
        dutIf.clear     = 1'b0;
        dutIf.isFeature = 1'b0;
        dutIf.refX      = '0;
        dutIf.refY      = '0;
        mPc = 0;
        mOv = 1'b0;
        setup028();
        repeat (3) @(negedge clock);
        #1;
        chk("rst_busy", dutIf.busy, 0);
        chk("rst_done", dutIf.done, 0);
        chk("rst_fbRdEn", dutIf.fbRdEn, 0);
        chk("rst_posCount", dutIf.posCount, 0);
        chk("rst_overflow", dutIf.overflow, 0);
        chk("rst_position", dutIf.position[63:0], 0);
        chk("rst_fbAddr", dutIf.fbAddr, 0);
        chk("rst_dbAddr", dutIf.dbAddr, 0);
        reset = 1'b0;

        // Match at DB entry 3, with a stray start during FETCH that must be ignored.
        runJob(10, 10, 1'b1, 1'b1, 16, 0, 5);
        // Match with isFeature=0: matPoint set, store untouched.
        runJob(12, 12, 1'b0, 1'b1, 16, 0, 0);

        // All-zero DB: full scan of 36 entries, no match.
        for (int i = 0; i < DBD; i++) dbMem[i] = '0;
        runJob(20, 20, 1'b1, 1'b0, 48, 0, 0);
        chk("dbAddr_hold_last", dutIf.dbAddr, 35);

        // Border references.
        runJob(0, 5, 1'b1, 1'b0, 2, 0, 0);
        runJob(159, 50, 1'b1, 1'b0, 2, 0, 0);
        runJob(30, 0, 1'b1, 1'b0, 2, 0, 0);
        runJob(30, 119, 1'b1, 1'b0, 2, 0, 0);

        // Tolerance boundary around (50,50) against DB entry 0 = all 100.
        fillFb(0);
        dbMem[0] = {8{8'd100}};
        base = 50*W + 50;
        for (int k = 0; k < 8; k++) fbMem[base + nbrOffset(k, W)] = (k < 5) ? 8'd104 : 8'd105;
        runJob(50, 50, 1'b1, 1'b0, 48, 0, 0);
        for (int k = 0; k < 8; k++)
            fbMem[base + nbrOffset(k, W)] = (k < 3) ? 8'd104 : ((k < 6) ? 8'd96 : 8'd105);
        runJob(50, 50, 1'b1, 1'b1, 13, 0, 0);

        // Explicit clear pulse.
        @(negedge clock); #1;
        dutIf.clear = 1'b1;
        @(negedge clock); #1;
        dutIf.clear = 1'b0;
        mPc = 0;
        mOv = 1'b0;
        chk("clear_posCount", dutIf.posCount, 0);
        chk("clear_isMatching", dutIf.isMatching, 0);

        // Fill the store and overflow it.
        setup028();
        for (int i = 0; i < 17; i++) runJob(10 + i, 10, 1'b1, 1'b1, 16, 0, 0);
        chk("full_posCount", dutIf.posCount, 16);
        chk("full_overflow", dutIf.overflow, 1);
        chk("full_slot15", dutIf.position[15*AW +: AW], 1625);

        // Clear coinciding with RECORD wins over a full store.
        runJob(40, 40, 1'b1, 1'b1, 16, 15, 0);
        runJob(41, 41, 1'b1, 1'b1, 16, 0, 0);

        // Reset while in COMPARE.
        @(negedge clock); #1;
        for (int k = 0; k < 8; k++) readQ.push_back(30*W + 30 + nbrOffset(k, W));
        dutIf.refX      = 8'd30;
        dutIf.refY      = 7'd30;
        dutIf.isFeature = 1'b1;
        dutIf.start     = 1'b1;
        @(negedge clock); #1;
        dutIf.start = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", dutIf.busy, 0);
        chk("midrst_done", dutIf.done, 0);
        chk("midrst_fbRdEn", dutIf.fbRdEn, 0);
        chk("midrst_dbAddr", dutIf.dbAddr, 0);
        chk("midrst_fbAddr", dutIf.fbAddr, 0);
        chk("midrst_posCount", dutIf.posCount, 0);
        chk("midrst_slot0", dutIf.position[AW-1:0], 0);
        chk("midrst_matPoint", dutIf.matPoint, 0);
        @(negedge clock); #1;
        reset = 1'b0;
        readQ.delete();
        readCnt = 0;
        mPc = 0;
        mOv = 1'b0;

        runJob(10, 10, 1'b1, 1'b1, 16, 0, 0);
        runJob(42, 42, 1'b1, 1'b1, 16, 15, 0);

        chk("sb_drained", sbQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
